// File: rtl/adpcm_pkg.sv
// Shared types and widths for the ADPCM stream controller and its byte path.
package adpcm_pkg;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;
endpackage

// File: rtl/adpcm_byte_fifo.sv
// Small synchronous FIFO with a registered head entry and a drop flag for pushes refused while full.
module adpcm_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic             dropped
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             do_pop;
    logic             do_push;

    // The extra pointer bit separates a full FIFO from an empty one.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dropped = push && full && !do_pop;

    assign head_data = mem_reg[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
                wr_ptr_reg                  <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end
endmodule

// File: rtl/adpcm_stream_ctrl.sv
// Run sequencer for the CIC+ADPCM compressor: clock dividers, block enable,
// warm-up discard, nibble packing and a byte FIFO with valid/ready output.
module adpcm_stream_ctrl
    import adpcm_pkg::*;
#(
    parameter int PDM_DIV    = 4,
    parameter int DECIM      = 16,
    parameter int WARMUP     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    output logic                pdm_clk,
    output logic                slow_clk,
    output logic                blk_en,
    input  logic                enc_valid,
    input  logic [NIBBLE_W-1:0] enc_code,
    output logic [BYTE_W-1:0]   byte_data,
    output logic                byte_valid,
    input  logic                byte_ready,
    output logic                overflow,
    output logic                busy
);
    localparam int PW = $clog2(PDM_DIV);
    localparam int DW = $clog2(DECIM);
    localparam int WW = $clog2(WARMUP + 1);

    state_t              state_reg, state_next;
    logic [PW-1:0]       pdm_cnt_reg;
    logic                pdm_clk_reg;
    logic [DW-1:0]       rise_cnt_reg;
    logic                slow_clk_reg;
    logic [2:0]          sync_reg;
    logic                enc_edge;
    logic [WW-1:0]       warm_cnt_reg;
    logic                half_reg;
    logic [NIBBLE_W-1:0] nibble_reg;
    logic                overflow_reg;
    logic                keep_running;
    logic                push;
    logic [BYTE_W-1:0]   push_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_dropped;

    assign enc_edge = sync_reg[1] & ~sync_reg[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_WARMUP;
            S_WARMUP: begin
                if (stop) begin
                    state_next = S_IDLE;
                end else if (enc_edge && warm_cnt_reg == WW'(WARMUP - 1)) begin
                    state_next = S_RUN;
                end
            end
            S_RUN:    if (stop) state_next = S_DRAIN;
            S_DRAIN:  state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign blk_en       = (state_reg == S_WARMUP) || (state_reg == S_RUN);
    assign keep_running = blk_en && ((state_next == S_WARMUP) || (state_next == S_RUN));

    // Dividers clear on the exit edge so both clocks read low in the same cycle blk_en drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdm_cnt_reg  <= '0;
            pdm_clk_reg  <= 1'b0;
            rise_cnt_reg <= '0;
            slow_clk_reg <= 1'b0;
        end else if (!keep_running) begin
            pdm_cnt_reg  <= '0;
            pdm_clk_reg  <= 1'b0;
            rise_cnt_reg <= '0;
            slow_clk_reg <= 1'b0;
        end else begin
            pdm_cnt_reg <= (pdm_cnt_reg == PW'(PDM_DIV - 1)) ? '0 : pdm_cnt_reg + 1'b1;
            if (pdm_cnt_reg == PW'(PDM_DIV / 2 - 1)) begin
                pdm_clk_reg  <= 1'b1;
                slow_clk_reg <= (rise_cnt_reg >= DW'(DECIM / 2));
                rise_cnt_reg <= (rise_cnt_reg == DW'(DECIM - 1)) ? '0 : rise_cnt_reg + 1'b1;
            end else if (pdm_cnt_reg == PW'(PDM_DIV - 1)) begin
                pdm_clk_reg <= 1'b0;
            end
        end
    end

    assign pdm_clk  = pdm_clk_reg;
    assign slow_clk = slow_clk_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], enc_valid};
        end
    end

    // enc_code is held stable by the encoder while enc_valid is high, so it is sampled directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt_reg <= '0;
            half_reg     <= 1'b0;
            nibble_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && start) begin
                warm_cnt_reg <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (fifo_dropped) overflow_reg <= 1'b1;
                if (state_reg == S_WARMUP && enc_edge) warm_cnt_reg <= warm_cnt_reg + 1'b1;
            end
            if (state_next == S_IDLE) begin
                half_reg <= 1'b0;
            end else if (state_reg == S_RUN && enc_edge) begin
                if (!half_reg) nibble_reg <= enc_code;
                half_reg <= !half_reg;
            end
        end
    end

    always_comb begin
        push      = 1'b0;
        push_data = {enc_code, nibble_reg};
        if (state_reg == S_RUN && enc_edge && half_reg) begin
            push = 1'b1;
        end else if (state_reg == S_DRAIN && half_reg) begin
            push      = 1'b1;
            push_data = {NIBBLE_W'(0), nibble_reg};
        end
    end

    adpcm_byte_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (byte_ready),
        .head_data (byte_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .dropped   (fifo_dropped)
    );

    assign byte_valid = !fifo_empty;
    assign overflow   = overflow_reg;
    assign busy       = (state_reg != S_IDLE) || !fifo_empty;
endmodule

// File: doc/adpcm_stream_ctrl.md
Name: adpcm_stream_ctrl

Overview:
Sequencer and output buffer for the CIC+ADPCM compressor.
- Derives the PDM clock and the decimation clock from the system clock, and gates the compressor's block enable.
- Discards the CIC settling samples, packs 4-bit ADPCM codes into bytes, and buffers them in a small FIFO with a valid/ready byte interface.
- Sits between the top-level pin mapping and the compressor, replacing direct pin drive of the compressor's clocks and enable.

Parameters:
- PDM_DIV, 4: clk cycles per pdm_clk period. Even, ≥2.
- DECIM, 16: pdm_clk periods per slow_clk period. Even, ≥2.
- WARMUP, 4: number of initial encoder codes discarded after start.
- FIFO_DEPTH, 4: byte FIFO entries. Power of two.

Ports:
- clk, in, 1: system clock. Single clock domain.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: one-cycle pulse; begins a capture run.
- stop, in, 1: one-cycle pulse; ends the capture run.
- pdm_clk, out, 1: compressor sample clock, registered.
- slow_clk, out, 1: compressor decimation clock, registered.
- blk_en, out, 1: compressor block enable.
- enc_valid, in, 1: compressor outValid. Asynchronous to clk.
- enc_code, in, 4: compressor encPcm. Stable while enc_valid is high.
- byte_data, out, 8: FIFO head byte.
- byte_valid, out, 1: FIFO not empty.
- byte_ready, in, 1: consumer accepts byte_data.
- overflow, out, 1: sticky; a byte was dropped.
- busy, out, 1: state != IDLE, or FIFO not empty.

Behaviour:
- Reset:
  - All outputs are 0.
  - State = IDLE; all counters, FIFO pointers and the nibble register are cleared.
- States: IDLE, WARMUP, RUN, DRAIN.
  - IDLE -> WARMUP on start. This clears overflow, the warmup counter and the clock dividers.
  - WARMUP -> RUN after WARMUP captured codes.
  - WARMUP -> IDLE on stop. Nothing is pushed.
  - RUN -> DRAIN on stop.
  - DRAIN -> IDLE after exactly 1 cycle.
  - start is ignored outside IDLE. stop is ignored in IDLE and DRAIN.
  - start and stop in the same cycle in IDLE: start wins.
- Clock generation (active only in WARMUP and RUN):
  - pdm_clk is low for PDM_DIV/2 cycles, then high for PDM_DIV/2 cycles.
  - slow_clk is low for DECIM/2 pdm periods, then high for DECIM/2 pdm periods. It toggles in the same clk cycle as a pdm_clk rising edge.
  - In IDLE and DRAIN, both clocks are forced low and the dividers are held at 0.
  - The first pdm_clk rise occurs PDM_DIV/2 cycles after leaving IDLE.
- blk_en = 1 in WARMUP and RUN, otherwise 0. It changes in the same cycle as the state register.
- Code capture:
  - enc_valid passes through a 2-flop synchroniser followed by rising-edge detection.
  - On a detected edge, enc_code is captured. Latency from the enc_valid rise to the capture cycle is 3 clk.
  - In WARMUP, a capture increments the warmup counter and the code is discarded.
  - In RUN, a capture feeds the packer.
  - Edges detected in IDLE or DRAIN are ignored.
- Packer:
  - The first code goes to byte[3:0] and sets the half flag.
  - The second code goes to byte[7:4]; the byte is pushed and the half flag is cleared.
  - In DRAIN with the half flag set, the byte is pushed with [7:4] = 0.
  - The half flag is cleared on every exit to IDLE.
- FIFO:
  - Pop when byte_valid && byte_ready.
  - Push while full with no pop in the same cycle: the byte is dropped and overflow is set.
  - Push while full with a pop in the same cycle: the push is accepted.
  - Push while empty: byte_valid rises on the next cycle (1-cycle latency); byte_data is the head byte, registered.
  - The FIFO keeps draining in IDLE.
  - Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.

Decomposition:
- Shared package adpcm_pkg holds:
  - state enum (IDLE, WARMUP, RUN, DRAIN)
  - NIBBLE_W = 4
  - BYTE_W = 8
- One sub-module: adpcm_byte_fifo, a parameterised synchronous FIFO with push/pop/full/empty. It is reused elsewhere for the PCM debug path.
- The synchroniser stays inline.

Test Plan:
1. Reset, then start with PDM_DIV=4, DECIM=16:
   - pdm_clk has period 4 clk; slow_clk has period 64 clk.
   - blk_en = 1 in the cycle after start.
2. WARMUP=4; apply six enc_valid pulses with codes 1..6:
   - Codes 1–4 are discarded.
   - One byte 0x65 appears with byte_valid; pop occurs with byte_ready = 1.
3. In RUN, send three codes A, B, C, then stop:
   - Bytes 0xBA, then 0x0C, are output.
   - State returns to IDLE; busy = 0 after both bytes are popped.
4. Hold byte_ready = 0 and push 5 bytes into a depth-4 FIFO:
   - The first 4 bytes are retained in order.
   - overflow = 1.
   - overflow is cleared by the next start.
5. FIFO full, and a push coincides with a pop (byte_ready = 1):
   - No overflow.
   - Entry count stays at 4.
6. Assert rst_n low mid-RUN with byte_valid = 1:
   - All outputs are 0 immediately.
   - After release: IDLE, FIFO empty, pdm_clk and slow_clk low.
